rng_digit_scanner: RTL

//  Multi-digit random-number display core: xorshift32 PRNG, unbiased 0-9 digit draw
//  (rejection sampling), N-digit shadow/display registers, time-multiplexed 7-seg scan.

---
 rtl/rng_digit_scanner_pkg.sv | 41 ++++
 rtl/rng_digit_scanner_if.sv | 24 ++
 rtl/rng_digit_scanner_seg7.sv | 26 ++
 rtl/rng_digit_scanner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rng_digit_scanner_pkg.sv
// Shared constants, types and the xorshift32 step for the random-digit display core.
package rng_digit_pkg;

    localparam int XS_A = 13;
    localparam int XS_B = 17;
    localparam int XS_C = 5;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        COMMIT = 2'd2
    } fsm_state_t;

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

    // A zero seed would lock xorshift at zero forever, so it maps to the default state.
    function automatic logic [31:0] seed_to_state(input logic [31:0] seed_zext,
                                                  input logic [31:0] default_seed);
        return (seed_zext == 32'd0) ? default_seed : seed_zext;
    endfunction

endpackage

// File: rtl/rng_digit_scanner_if.sv
// Control/display bundle between the tile wrapper and the random-digit display core.
interface rng_digit_scanner_if #(
    parameter int NUM_DIGITS = 2,
    parameter int SEED_W     = 6
);
    logic [SEED_W-1:0]     seed;
    logic                  seed_load;
    logic                  run_en;
    logic                  step;
    logic [6:0]            segments;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  new_value;
    logic                  busy;

    modport master (
        output seed, seed_load, run_en, step,
        input  segments, digit_en, new_value, busy
    );

    modport slave (
        input  seed, seed_load, run_en, step,
        output segments, digit_en, new_value, busy
    );
endinterface

// File: rtl/rng_digit_scanner_seg7.sv
// Hex-nibble to 7-segment decoder; values above 9 blank the digit.
module seg7
    import rng_digit_pkg::*;
(
    input  logic [3:0] counter,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (counter)
            4'd0: segments = SEG_0;
            4'd1: segments = SEG_1;
            4'd2: segments = SEG_2;
            4'd3: segments = SEG_3;
            4'd4: segments = SEG_4;
            4'd5: segments = SEG_5;
            4'd6: segments = SEG_6;
            4'd7: segments = SEG_7;
            4'd8: segments = SEG_8;
            4'd9: segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/rng_digit_scanner.sv
// Multi-digit random display: xorshift32 PRNG, rejection-sampled 0-9 digits,
// shadow/display digit banks and a time-multiplexed 7-segment scan.
module rng_digit_scanner
    import rng_digit_pkg::*;
#(
    parameter int          NUM_DIGITS   = 2,
    parameter int          TICK_MAX     = 999,
    parameter int          SCAN_DIV     = 15,
    parameter int          SEED_W       = 6,
    parameter logic [31:0] DEFAULT_SEED = 32'h1,
    parameter int          MAX_REJECT   = 7
) (
    input logic                 clk,
    input logic                 reset,
    rng_digit_scanner_if.slave  bus
);

    localparam int IDX_W  = $clog2(NUM_DIGITS + 1);
    localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W = $clog2(TICK_MAX + 2);
    localparam int SCAN_W = $clog2(SCAN_DIV + 2);
    localparam int REJ_W  = $clog2(MAX_REJECT + 1);

    fsm_state_t        fsm_q, fsm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [REJ_W-1:0]  rej_q, rej_d;
    logic [31:0]       state_q;
    logic              new_value_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [SEL_W-1:0]  digit_sel_q;
    logic [3:0]        shadow_q  [NUM_DIGITS];
    logic [3:0]        display_q [NUM_DIGITS];

    logic [31:0] xs_next;
    logic [3:0]  nib;
    logic [3:0]  digit;
    logic        accept;
    logic        tick;
    logic        draw_req;
    logic        gen_step;
    logic        shadow_we;
    logic        commit;
    logic [3:0]  shown_digit;

    assign tick     = bus.run_en && (tick_cnt_q == TICK_W'(TICK_MAX));
    assign draw_req = tick || bus.step;

    assign xs_next = xorshift32_step(state_q);
    assign nib     = xs_next[3:0];
    // After MAX_REJECT-1 consecutive rejections the next nibble is folded into 0..5.
    assign accept  = (nib < 4'd10) || (rej_q == REJ_W'(MAX_REJECT - 1));
    assign digit   = (nib < 4'd10) ? nib : (nib - 4'd10);

    always_comb begin
        fsm_d     = fsm_q;
        idx_d     = idx_q;
        rej_d     = rej_q;
        gen_step  = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (draw_req) begin
                    fsm_d = GEN;
                    idx_d = '0;
                    rej_d = '0;
                end
            end
            GEN: begin
                gen_step = 1'b1;
                if (accept) begin
                    shadow_we = 1'b1;
                    rej_d     = '0;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        fsm_d = COMMIT;
                    end
                end else begin
                    rej_d = rej_q + REJ_W'(1);
                end
            end
            COMMIT: begin
                commit = 1'b1;
                fsm_d  = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        // A seed load wins over everything and throws away a draw in progress.
        if (bus.seed_load) begin
            fsm_d     = IDLE;
            gen_step  = 1'b0;
            shadow_we = 1'b0;
            commit    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            idx_q       <= '0;
            rej_q       <= '0;
            new_value_q <= 1'b0;
            state_q     <= DEFAULT_SEED;
        end else begin
            fsm_q       <= fsm_d;
            idx_q       <= idx_d;
            rej_q       <= rej_d;
            new_value_q <= commit;
            if (bus.seed_load) begin
                state_q <= seed_to_state(32'(bus.seed), DEFAULT_SEED);
            end else if (gen_step) begin
                state_q <= xs_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i]  <= '0;
                display_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (shadow_we && (idx_q == IDX_W'(i))) begin
                    shadow_q[i] <= digit;
                end
                if (commit) begin
                    display_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            scan_cnt_q  <= '0;
            digit_sel_q <= '0;
        end else begin
            if (bus.run_en) begin
                tick_cnt_q <= tick ? '0 : (tick_cnt_q + TICK_W'(1));
            end
            if (scan_cnt_q == SCAN_W'(SCAN_DIV)) begin
                scan_cnt_q  <= '0;
                digit_sel_q <= (digit_sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0
                                                                       : (digit_sel_q + SEL_W'(1));
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
        end
    end

    // Segments and enable both derive from the registered selector, so they switch together.
    always_comb begin
        shown_digit  = '0;
        bus.digit_en = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel_q == SEL_W'(i)) begin
                shown_digit     = display_q[i];
                bus.digit_en[i] = 1'b1;
            end
        end
    end

    seg7 u_seg7 (
        .counter  (shown_digit),
        .segments (bus.segments)
    );

    assign bus.new_value = new_value_q;
    assign bus.busy      = (fsm_q != IDLE);

endmodule
